muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider datapath.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, nstate;

  logic [1:0]         op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] prod;
  logic               is_div;
  logic               last;

  assign sgn    = ~op[0];
  assign abs_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sgn && b[WIDTH-1]) ? -b : b;
  assign is_div = op_q[1];
  assign last   = (cnt == CW'(WIDTH - 1));

  // Shift-add: low half holds the remaining multiplier bits.
  assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? opb : '0)};
  assign mul_nxt = {msum, acc[WIDTH-1:1]};
  assign prod    = neg_q ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] rem;
  logic             neg_r;
  logic             dz;
  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rmd;

  assign shr     = {rem, acc[WIDTH-1]};
  assign trial   = shr - {1'b0, opb};
  assign fits    = ~trial[WIDTH];
  assign rem_nxt = fits ? trial[WIDTH-1:0] : shr[WIDTH-1:0];
  assign q_nxt   = {acc[WIDTH-2:0], fits};
  // A zero divisor yields an all-ones quotient regardless of sign.
  assign quo     = dz ? '1
                 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rmd     = neg_r ? -rem : rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op[1] && !DIV_EN) nstate = FIX;
          else                  nstate = CALC;
        end
      end
      CALC: if (last) nstate = FIX;
      FIX:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem    <= '0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}}, abs_a};
            opb   <= abs_b;
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            rem   <= '0;
            neg_r <= sgn & a[WIDTH-1];
            dz    <= (b == '0);
`endif
          end else begin
            if (hi_we) hi_q <= a;
            if (lo_we) lo_q <= a;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, q_nxt};
            rem <= rem_nxt;
          end else begin
            acc <= mul_nxt;
          end
`else
          acc <= mul_nxt;
`endif
        end
        FIX: begin
          if (!is_div) begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
`ifdef MULDIV_DIV_EN
          else begin
            hi_q <= rmd;
            lo_q <= quo;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
